// File: rtl/animation_draw_car_pkg.sv
// Shared constants and state encoding for the car sprite draw/erase blocks.
package animation_draw_car_pkg;

    // Default visible screen area; pixels at or beyond these limits are clipped.
    localparam logic [8:0] DEF_X_SCREEN_PIXELS = 9'd160;
    localparam logic [7:0] DEF_Y_SCREEN_PIXELS = 8'd120;

    // Colour code that marks a see-through sprite pixel.
    localparam logic [8:0] DEF_TRANSPARENT     = 9'h1FF;

    // Sprite geometry: 15x15 pixels per heading frame.
    localparam int         SPRITE_W   = 15;
    localparam int         SPRITE_PIX = SPRITE_W * SPRITE_W;
    localparam logic [7:0] LAST_IDX   = 8'(SPRITE_PIX - 1);
    localparam logic [3:0] LAST_COL   = 4'(SPRITE_W - 1);

    // Sequencer states, shared by the draw and erase blocks.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_t;

    // First ROM word of the frame for a given heading.
    function automatic logic [10:0] sprite_base(input logic [2:0] dir);
        return {8'd0, dir} * 11'd225;
    endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// Walks a 15x15 sprite in raster order: linear index plus row/column,
// without any divide or modulo. Saturates on the last pixel.
module sprite_pixel_counter
    import animation_draw_car_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] idx,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       last
);

    assign last = (idx == LAST_IDX);

    // Advance idx/col/row once per enabled cycle; hold once the last pixel is reached.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx <= 8'd0;
            row <= 4'd0;
            col <= 4'd0;
        end else if (clr) begin
            idx <= 8'd0;
            row <= 4'd0;
            col <= 4'd0;
        end else if (en && !last) begin
            idx <= idx + 8'd1;
            if (col == LAST_COL) begin
                col <= 4'd0;
                row <= row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end
    end

endmodule

// File: rtl/animation_draw_car.sv
// Paints the 15x15 car sprite for one of 8 headings at a latched (x,y).
// Handshake: iDrawCar is a start request sampled only while idle; oBusy is
// high for the whole draw and oDrawCarDone pulses for one cycle at the end.
// Each FETCH cycle issues one ROM address; the ROM answers one cycle later
// and the pixel reaches the VGA outputs the cycle after that.
module animation_draw_car
    import animation_draw_car_pkg::*;
#(
    parameter logic [8:0] X_SCREEN_PIXELS = DEF_X_SCREEN_PIXELS,
    parameter logic [7:0] Y_SCREEN_PIXELS = DEF_Y_SCREEN_PIXELS,
    parameter logic [8:0] TRANSPARENT     = DEF_TRANSPARENT
)
(
    input  logic        iClock,
    input  logic        iResetn,
    input  logic        iDrawCar,
    input  logic [7:0]  iX,
    input  logic [6:0]  iY,
    input  logic [2:0]  iDir,
    input  logic [8:0]  iSpriteQ,
    output logic [10:0] oAddress,
    output logic [7:0]  oX,
    output logic [6:0]  oY,
    output logic [8:0]  oColour,
    output logic        oPlot,
    output logic        oBusy,
    output logic        oDrawCarDone
);

    draw_state_t state, next_state;

    logic [7:0] x_l;
    logic [6:0] y_l;
    logic [2:0] dir_l;

    logic       cnt_en, cnt_clr, cnt_last;
    logic [7:0] idx;
    logic [3:0] row, col;

    logic       drain_cnt;

    logic       s1_valid;
    logic [3:0] s1_col, s1_row;

    logic [8:0] sx;
    logic [7:0] sy;

    sprite_pixel_counter u_counter (
        .clk    (iClock),
        .resetn (iResetn),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .idx    (idx),
        .row    (row),
        .col    (col),
        .last   (cnt_last)
    );

    // State register.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Next-state logic and counter controls.
    always_comb begin
        next_state = state;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iDrawCar) begin
                    cnt_clr    = 1'b1;
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                cnt_en = 1'b1;
                if (cnt_last) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Two-cycle drain timer lets the last pixel clear the ROM and output stages.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn)                drain_cnt <= 1'b0;
        else if (state == ST_DRAIN)  drain_cnt <= ~drain_cnt;
        else                         drain_cnt <= 1'b0;
    end

    // Capture position and heading at the start of a draw; inputs are ignored afterwards.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            x_l   <= 8'd0;
            y_l   <= 7'd0;
            dir_l <= 3'd0;
        end else if (state == ST_IDLE && iDrawCar) begin
            x_l   <= iX;
            y_l   <= iY;
            dir_l <= iDir;
        end
    end

    assign oAddress = sprite_base(dir_l) + {3'd0, idx};

    // Carry the pixel position alongside the ROM access so it lines up with iSpriteQ.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            s1_valid <= 1'b0;
            s1_col   <= 4'd0;
            s1_row   <= 4'd0;
        end else begin
            s1_valid <= (state == ST_FETCH);
            s1_col   <= col;
            s1_row   <= row;
        end
    end

    // Screen coordinates are widened by one bit so off-screen pixels never wrap.
    assign sx = {1'b0, x_l} + {5'd0, s1_col};
    assign sy = {1'b0, y_l} + {4'd0, s1_row};

    // Output stage: load every valid pixel, strobe only visible opaque ones.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oX      <= 8'd0;
            oY      <= 7'd0;
            oColour <= 9'd0;
            oPlot   <= 1'b0;
        end else if (s1_valid) begin
            oX      <= sx[7:0];
            oY      <= sy[6:0];
            oColour <= iSpriteQ;
            oPlot   <= (iSpriteQ != TRANSPARENT) &&
                       (sx < X_SCREEN_PIXELS) &&
                       (sy < Y_SCREEN_PIXELS);
        end else begin
            oPlot   <= 1'b0;
        end
    end

    assign oBusy        = (state != ST_IDLE);
    assign oDrawCarDone = (state == ST_DONE);

endmodule
